// File: rtl/memory_pkg.sv
// Shared types and defaults for the L1 d-cache to L2 synchronisation unit.
//
// Contents:
//   L1DC_* defaults        default geometry of the L1 d-cache
//   idx_width()            index width for a power-of-two count (at least 1 bit)
//   needs_writeback()      decides whether a read-back entry must go to L2
//   sat_inc32()            saturating 32-bit increment (performance counters)
//   l1dc_sync_state_t      sync FSM states
//   l1dc_upd_req_t         (set,way) read request at default geometry
//   l1dc_upd_ans_t         read answer at default geometry
package memory_pkg;

    localparam int L1DC_N_SETS      = 64;
    localparam int L1DC_N_WAYS      = 4;
    localparam int L1DC_LINE_ADDR_W = 58;
    localparam int L1DC_LINE_W      = 512;

    // A single-way cache still needs a 1-bit way port, so never return 0.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Only lines that are both valid and dirty hold data L2 does not have.
    function automatic logic needs_writeback(input logic valid, input logic dirty);
        return valid & dirty;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    typedef enum logic [2:0] {
        SYNC_IDLE,
        SYNC_RD_REQ,
        SYNC_RD_WAIT,
        SYNC_WB_REQ,
        SYNC_CLR,
        SYNC_NEXT,
        SYNC_DONE
    } l1dc_sync_state_t;

    typedef struct packed {
        logic [idx_width(L1DC_N_SETS)-1:0] set;
        logic [idx_width(L1DC_N_WAYS)-1:0] way;
    } l1dc_upd_req_t;

    typedef struct packed {
        logic                        valid;
        logic                        dirty;
        logic [L1DC_LINE_ADDR_W-1:0] addr;
        logic [L1DC_LINE_W-1:0]      line;
    } l1dc_upd_ans_t;

endpackage

// File: rtl/l1dc_l2c_sync_unit_walker.sv
// l1dc_sync_walker: (set,way) iterator for the d-cache sync walk.
// Way is the inner loop; last_o flags the final entry (N_SETS-1, N_WAYS-1).
//
// Ports:
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   clear_i          restart the walk at (0,0)
//   advance_i        step to the next entry
//   set_o, way_o     current entry
//   last_o           current entry is the last one
module l1dc_sync_walker
    import memory_pkg::*;
#(
    parameter int N_SETS = L1DC_N_SETS,
    parameter int N_WAYS = L1DC_N_WAYS
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         clear_i,
    input  logic                         advance_i,
    output logic [idx_width(N_SETS)-1:0] set_o,
    output logic [idx_width(N_WAYS)-1:0] way_o,
    output logic                         last_o
);

    localparam int SET_W = idx_width(N_SETS);
    localparam int WAY_W = idx_width(N_WAYS);
    localparam logic [SET_W-1:0] LAST_SET = SET_W'(N_SETS - 1);
    localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(N_WAYS - 1);

    logic [SET_W-1:0] set_q, set_d;
    logic [WAY_W-1:0] way_q, way_d;

    // Counter update: clear wins over advance; set only moves when way wraps.
    always_comb begin
        set_d = set_q;
        way_d = way_q;
        if (clear_i) begin
            set_d = '0;
            way_d = '0;
        end else if (advance_i) begin
            if (way_q == LAST_WAY) begin
                way_d = '0;
                set_d = (set_q == LAST_SET) ? '0 : set_q + 1'b1;
            end else begin
                way_d = way_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            set_q <= '0;
            way_q <= '0;
        end else begin
            set_q <= set_d;
            way_q <= way_d;
        end
    end

    assign set_o  = set_q;
    assign way_o  = way_q;
    assign last_o = (set_q == LAST_SET) && (way_q == LAST_WAY);

endmodule

// File: rtl/l1dc_l2c_sync_unit.sv
// l1dc_l2c_sync_unit: on a sync request from the control FSM, walks every
// (set,way) of the L1 d-cache, writes valid+dirty lines back to L2 through the
// L2 arbiter, clears their dirty bits and then raises l2c_update_done_o.
//
// Ports:
//   clk_i, rst_n_i                      clock, asynchronous active-low reset
//   synch_l1dc_l2c_i / l2c_update_done_o  4-phase request/done with control FSM
//   abort_i                             drop an in-flight sync
//   upd_l1dc_* / l1dc_upd_*             d-cache entry read, answer, dirty clear
//   upd_l2arb_* / l2arb_upd_req_rdy_i   writeback to the L2 arbiter
//
// Optional feature (macro L1DC_SYNC_PERF_CNT_EN): adds sync_wb_cnt_o (lines
// written back in the last completed sync) and sync_cycles_o (cycles from
// request acceptance to DONE), both saturating.
module l1dc_l2c_sync_unit
    import memory_pkg::*;
#(
    parameter int N_SETS      = L1DC_N_SETS,
    parameter int N_WAYS      = L1DC_N_WAYS,
    parameter int LINE_ADDR_W = L1DC_LINE_ADDR_W,
    parameter int LINE_W      = L1DC_LINE_W
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         synch_l1dc_l2c_i,
    input  logic                         abort_i,
    output logic                         l2c_update_done_o,
    output logic                         upd_l1dc_req_valid_o,
    input  logic                         l1dc_upd_req_rdy_i,
    output logic [idx_width(N_SETS)-1:0] upd_l1dc_set_o,
    output logic [idx_width(N_WAYS)-1:0] upd_l1dc_way_o,
    input  logic                         l1dc_upd_ans_valid_i,
    input  logic                         l1dc_upd_valid_i,
    input  logic                         l1dc_upd_dirty_i,
    input  logic [LINE_ADDR_W-1:0]       l1dc_upd_addr_i,
    input  logic [LINE_W-1:0]            l1dc_upd_line_i,
    output logic                         upd_l1dc_clr_dirty_o,
    output logic                         upd_l2arb_req_valid_o,
    input  logic                         l2arb_upd_req_rdy_i,
    output logic [LINE_ADDR_W-1:0]       upd_l2arb_addr_o,
    output logic [LINE_W-1:0]            upd_l2arb_line_o
`ifdef L1DC_SYNC_PERF_CNT_EN
    ,
    output logic [31:0]                  sync_wb_cnt_o,
    output logic [31:0]                  sync_cycles_o
`endif
);

    l1dc_sync_state_t       state_q, state_d;
    logic [LINE_ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0]      line_q, line_d;
    logic                   done_q, done_d;
    logic                   walk_clear, walk_advance, walk_last;

    assign walk_clear   = (state_q == SYNC_IDLE) && synch_l1dc_l2c_i;
    assign walk_advance = (state_q == SYNC_NEXT);

    l1dc_sync_walker #(
        .N_SETS (N_SETS),
        .N_WAYS (N_WAYS)
    ) u_walker (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clear_i   (walk_clear),
        .advance_i (walk_advance),
        .set_o     (upd_l1dc_set_o),
        .way_o     (upd_l1dc_way_o),
        .last_o    (walk_last)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= SYNC_IDLE;
            addr_q  <= '0;
            line_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            done_q  <= done_d;
        end
    end

    // Abort beats any handshake completing in the same cycle, so an aborted
    // writeback leaves the entry dirty and it is simply rewritten next sync.
    // A dropped request is only honoured at entry boundaries (NEXT), so no
    // handshake is ever abandoned half way.
    always_comb begin
        state_d = state_q;
        if (abort_i && (state_q != SYNC_IDLE)) begin
            state_d = SYNC_IDLE;
        end else begin
            unique case (state_q)
                SYNC_IDLE:    if (synch_l1dc_l2c_i) state_d = SYNC_RD_REQ;
                SYNC_RD_REQ:  if (l1dc_upd_req_rdy_i) state_d = SYNC_RD_WAIT;
                SYNC_RD_WAIT: begin
                    if (l1dc_upd_ans_valid_i) begin
                        state_d = needs_writeback(l1dc_upd_valid_i, l1dc_upd_dirty_i)
                                  ? SYNC_WB_REQ : SYNC_NEXT;
                    end
                end
                SYNC_WB_REQ:  if (l2arb_upd_req_rdy_i) state_d = SYNC_CLR;
                SYNC_CLR:     state_d = SYNC_NEXT;
                SYNC_NEXT: begin
                    if (!synch_l1dc_l2c_i) state_d = SYNC_IDLE;
                    else if (walk_last)    state_d = SYNC_DONE;
                    else                   state_d = SYNC_RD_REQ;
                end
                SYNC_DONE:    if (!synch_l1dc_l2c_i) state_d = SYNC_IDLE;
                default:      state_d = SYNC_IDLE;
            endcase
        end
    end

    // Entry capture and registered done; done falls the cycle after the request drops.
    always_comb begin
        addr_d = addr_q;
        line_d = line_q;
        if ((state_q == SYNC_RD_WAIT) && l1dc_upd_ans_valid_i) begin
            addr_d = l1dc_upd_addr_i;
            line_d = l1dc_upd_line_i;
        end
        done_d = (state_q == SYNC_DONE) && synch_l1dc_l2c_i && !abort_i;
    end

    // Outputs decode straight from the state, so an abort or reset drops every valid at once.
    always_comb begin
        upd_l1dc_req_valid_o  = (state_q == SYNC_RD_REQ);
        upd_l2arb_req_valid_o = (state_q == SYNC_WB_REQ);
        upd_l1dc_clr_dirty_o  = (state_q == SYNC_CLR);
        upd_l2arb_addr_o      = addr_q;
        upd_l2arb_line_o      = line_q;
        l2c_update_done_o     = done_q;
    end

`ifdef L1DC_SYNC_PERF_CNT_EN
    logic [31:0] run_wb_q, run_wb_d, run_cyc_q, run_cyc_d;
    logic [31:0] wb_cnt_q, wb_cnt_d, cyc_cnt_q, cyc_cnt_d;

    // Running counts restart on acceptance and are published only on DONE entry,
    // so an aborted or dropped sync leaves the previous results visible.
    always_comb begin
        run_wb_d  = run_wb_q;
        run_cyc_d = run_cyc_q;
        wb_cnt_d  = wb_cnt_q;
        cyc_cnt_d = cyc_cnt_q;
        if (walk_clear) begin
            run_wb_d  = '0;
            run_cyc_d = '0;
        end else if ((state_q != SYNC_IDLE) && (state_q != SYNC_DONE)) begin
            run_cyc_d = sat_inc32(run_cyc_q);
            if ((state_q == SYNC_WB_REQ) && l2arb_upd_req_rdy_i && !abort_i) begin
                run_wb_d = sat_inc32(run_wb_q);
            end
            if ((state_q == SYNC_NEXT) && (state_d == SYNC_DONE)) begin
                wb_cnt_d  = run_wb_q;
                cyc_cnt_d = sat_inc32(run_cyc_q);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            run_wb_q  <= '0;
            run_cyc_q <= '0;
            wb_cnt_q  <= '0;
            cyc_cnt_q <= '0;
        end else begin
            run_wb_q  <= run_wb_d;
            run_cyc_q <= run_cyc_d;
            wb_cnt_q  <= wb_cnt_d;
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

    assign sync_wb_cnt_o = wb_cnt_q;
    assign sync_cycles_o = cyc_cnt_q;
`endif

    // Handshake stability (abort is the only legal way to withdraw a request)
    // and single-cycle dirty clear.
    a_rd_stable: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (upd_l1dc_req_valid_o && !l1dc_upd_req_rdy_i && !abort_i) |=>
        (upd_l1dc_req_valid_o && $stable(upd_l1dc_set_o) && $stable(upd_l1dc_way_o)));

    a_wb_stable: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (upd_l2arb_req_valid_o && !l2arb_upd_req_rdy_i && !abort_i) |=>
        (upd_l2arb_req_valid_o && $stable(upd_l2arb_addr_o) && $stable(upd_l2arb_line_o)));

    a_clr_single: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        upd_l1dc_clr_dirty_o |=> !upd_l1dc_clr_dirty_o);

endmodule
